// File: rtl/psum_accumulator.sv
// -----------------------------------------------------------------------------
// psum_accumulator
//
// Sums cfg_len consecutive signed products from the shift PEs into one partial
// sum. It then rounds the sum half-up, shifts it right by cfg_frac (arithmetic),
// saturates it to OUT_WIDTH and presents it through a valid/ready handshake.
// One result is held at a time. While a result waits in HOLD, in_ready is low,
// so each block costs one bubble cycle.
//
// Ports
//   clk        in   1            clock, all state changes on the rising edge
//   rst        in   1            synchronous active-high reset
//   cfg_len    in   LEN_WIDTH    products per result (0 behaves as 1),
//                                sampled on the first beat of a block
//   cfg_frac   in   FRAC_WIDTH   right shift applied to the sum, sampled with
//                                cfg_len
//   in_valid   in   1            product beat valid
//   in_ready   out  1            block can accept a beat (low while holding)
//   in_data    in   INTER_WIDTH  signed product
//   out_valid  out  1            result valid
//   out_ready  in   1            consumer accepts the result
//   out_data   out  OUT_WIDTH    signed, rounded, saturated result
// -----------------------------------------------------------------------------
module psum_accumulator #(
    parameter int INTER_WIDTH = 16,
    parameter int LEN_WIDTH   = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16,
    parameter int FRAC_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN_WIDTH-1:0]   cfg_len,
    input  logic [FRAC_WIDTH-1:0]  cfg_frac,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INTER_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // The rounding stage works one bit wider than the accumulator. The
    // half-LSB add can then never wrap, even for the largest legal sum.
    localparam logic signed [ACC_WIDTH:0] ONE_EXT  = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] ZERO_EXT = {(ACC_WIDTH+1){1'b0}};
    localparam logic signed [ACC_WIDTH:0] OUT_MAX_EXT =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN_EXT =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [FRAC_WIDTH-1:0] FRAC_ZERO = {FRAC_WIDTH{1'b0}};
    localparam logic [FRAC_WIDTH-1:0] FRAC_ONE  = {{(FRAC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    // Rounds half-up, shifts arithmetically by frac, and clamps the result
    // to the signed OUT_WIDTH range.
    function automatic logic [OUT_WIDTH-1:0] round_sat(
        input logic [ACC_WIDTH-1:0]  sum,
        input logic [FRAC_WIDTH-1:0] frac
    );
        logic signed [ACC_WIDTH:0] sum_ext;
        logic signed [ACC_WIDTH:0] half;
        logic signed [ACC_WIDTH:0] rounded;
        logic signed [ACC_WIDTH:0] shifted;
        logic [OUT_WIDTH-1:0]      res;
        sum_ext = $signed({sum[ACC_WIDTH-1], sum});
        if (frac != FRAC_ZERO) begin
            half = ONE_EXT << (frac - FRAC_ONE);
        end else begin
            half = ZERO_EXT;
        end
        rounded = sum_ext + half;
        shifted = rounded >>> frac;
        if (shifted > OUT_MAX_EXT) begin
            res = OUT_MAX_EXT[OUT_WIDTH-1:0];
        end else if (shifted < OUT_MIN_EXT) begin
            res = OUT_MIN_EXT[OUT_WIDTH-1:0];
        end else begin
            res = shifted[OUT_WIDTH-1:0];
        end
        return res;
    endfunction

    logic [1:0]            state_r;
    logic [ACC_WIDTH-1:0]  acc_r;
    logic [LEN_WIDTH-1:0]  cnt_r;
    logic [LEN_WIDTH-1:0]  len_q_r;
    logic [FRAC_WIDTH-1:0] frac_q_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic [OUT_WIDTH-1:0]  out_data_r;

    logic                  beat_s;
    logic [ACC_WIDTH-1:0]  in_data_ext_s;
    logic [LEN_WIDTH-1:0]  len_eff_s;
    logic [LEN_WIDTH-1:0]  cnt_inc_s;
    logic [ACC_WIDTH-1:0]  sum_next_s;
    logic [FRAC_WIDTH-1:0] frac_sel_s;
    logic                  last_beat_s;
    logic                  release_s;
    logic [1:0]            state_next_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    assign beat_s        = in_valid && in_ready_r;
    assign in_data_ext_s = {{(ACC_WIDTH-INTER_WIDTH){in_data[INTER_WIDTH-1]}}, in_data};
    assign len_eff_s     = (cfg_len == LEN_ZERO) ? LEN_ONE : cfg_len;
    // cnt_r stays below len_q_r. len_q_r fits in LEN_WIDTH, so this never wraps.
    assign cnt_inc_s     = cnt_r + LEN_ONE;

    // Next-state decode, next running sum and end-of-block detection.
    always_comb begin
        state_next_s = state_r;
        sum_next_s   = acc_r;
        frac_sel_s   = frac_q_r;
        last_beat_s  = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The first beat loads the accumulator. The live cfg_frac
                // is used because frac_q_r is only captured on this edge.
                sum_next_s = in_data_ext_s;
                frac_sel_s = cfg_frac;
                if (beat_s) begin
                    last_beat_s  = (len_eff_s == LEN_ONE);
                    state_next_s = (len_eff_s == LEN_ONE) ? ST_HOLD : ST_ACC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                sum_next_s = acc_r + in_data_ext_s;
                frac_sel_s = frac_q_r;
                if (beat_s) begin
                    last_beat_s  = (cnt_inc_s == len_q_r);
                    state_next_s = (cnt_inc_s == len_q_r) ? ST_HOLD : ST_ACC;
                end else begin
                    state_next_s = ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    release_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accumulator, beat counter and per-block configuration capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {ACC_WIDTH{1'b0}};
            cnt_r    <= LEN_ZERO;
            len_q_r  <= LEN_ONE;
            frac_q_r <= FRAC_ZERO;
        end else if (beat_s) begin
            acc_r <= sum_next_s;
            if (state_r == ST_IDLE) begin
                len_q_r  <= len_eff_s;
                frac_q_r <= cfg_frac;
                cnt_r    <= LEN_ONE;
            end else begin
                cnt_r <= cnt_inc_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result register and handshake flags. in_ready is kept as the
    // complement of out_valid so that both come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            out_data_r  <= {OUT_WIDTH{1'b0}};
        end else if (last_beat_s) begin
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b0;
            out_data_r  <= round_sat(sum_next_s, frac_sel_s);
        end else if (release_s) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            out_valid_r <= out_valid_r;
            in_ready_r  <= in_ready_r;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_psum_accumulator
//
// Bench for psum_accumulator. The first part drives directed blocks. The
// second part drives random blocks with idle gaps, mid-block cfg changes and
// random hold lengths. Expected results come from a plain integer model of
// sum, round, shift and clamp.
// -----------------------------------------------------------------------------
module tb_psum_accumulator;

    logic        clk;
    logic        rst;
    logic [7:0]  cfg_len;
    logic [2:0]  cfg_frac;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_cmp;
    int n_bad;
    int beats [0:299];

    psum_accumulator #(
        .INTER_WIDTH(16),
        .LEN_WIDTH  (8),
        .ACC_WIDTH  (24),
        .OUT_WIDTH  (16),
        .FRAC_WIDTH (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_len  (cfg_len),
        .cfg_frac (cfg_frac),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp = n_cmp + 1;
        if (obs != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum, round half up, floor shift, clamp.
    function automatic longint model_result(input int n, input int frac);
        longint s;
        longint r;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s = s + longint'(beats[i]);
        end
        if (frac > 0) begin
            r = (s + (longint'(1) << (frac - 1))) >>> frac;
        end else begin
            r = s;
        end
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Drives n beats of beats[] as one block, checks latency and result,
    // holds the result for 'hold' cycles, then releases it.
    task automatic run_block(input string tag, input int len_cfg, input int frac,
                             input int n, input int alt_len, input int alt_frac,
                             input int hold, input int max_gap, input longint exp);
        int gaps;
        for (int i = 0; i < n; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = 16'(beats[i]);
            cfg_len  = (i == 0) ? 8'(len_cfg) : 8'(alt_len);
            cfg_frac = (i == 0) ? 3'(frac) : 3'(alt_frac);
            check_eq({tag, "/in_ready_beat"}, longint'(in_ready), 1);
            if (i == n - 1) begin
                check_eq({tag, "/out_valid_pre"}, longint'(out_valid), 0);
            end
            step();
        end
        in_valid = 1'b0;
        check_eq({tag, "/out_valid_lat"}, longint'(out_valid), 1);
        check_eq({tag, "/out_data"}, longint'($signed(out_data)), exp);
        check_eq({tag, "/in_ready_hold"}, longint'(in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            step();
            check_eq({tag, "/hold_valid"}, longint'(out_valid), 1);
            check_eq({tag, "/hold_data"}, longint'($signed(out_data)), exp);
            check_eq({tag, "/hold_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, "/rel_valid"}, longint'(out_valid), 0);
        check_eq({tag, "/rel_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        int len_cfg;
        int n;
        int frac;
        logic [15:0] r16;
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        cfg_len   = 8'd0;
        cfg_frac  = 3'd0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;
        step();
        step();
        check_eq("reset/out_valid", longint'(out_valid), 0);
        check_eq("reset/in_ready", longint'(in_ready), 1);
        check_eq("reset/out_data", longint'($signed(out_data)), 0);
        rst = 1'b0;
        step();

        // Basic sum, no idle gaps.
        beats[0] = 10; beats[1] = 20; beats[2] = -5; beats[3] = 7;
        run_block("t1", 4, 0, 4, 4, 0, 0, 0, 32);

        // Rounding with frac=7, including the negative and half cases.
        beats[0] = 192;  run_block("t2a", 1, 7, 1, 1, 7, 0, 0, 2);
        beats[0] = -192; run_block("t2b", 1, 7, 1, 1, 7, 0, 0, -1);
        beats[0] = 64;   run_block("t2c", 1, 7, 1, 1, 7, 0, 0, 1);
        beats[0] = 63;   run_block("t2d", 1, 7, 1, 1, 7, 0, 0, 0);

        // Saturation at both rails.
        for (int i = 0; i < 4; i++) beats[i] = 32767;
        run_block("t3a", 4, 0, 4, 4, 0, 0, 0, 32767);
        for (int i = 0; i < 4; i++) beats[i] = -32768;
        run_block("t3b", 4, 0, 4, 4, 0, 0, 0, -32768);

        // Result held for 5 cycles while junk is offered on the input.
        beats[0] = 100; beats[1] = 200; beats[2] = 300; beats[3] = 400;
        run_block("t4", 4, 2, 4, 4, 2, 5, 0, 250);

        // A zero length means one beat. A length changed mid-block is ignored.
        beats[0] = 9;
        run_block("t5a", 0, 0, 1, 0, 0, 0, 0, 9);
        beats[0] = 1; beats[1] = 2; beats[2] = 3;
        run_block("t5b", 3, 0, 3, 5, 0, 0, 0, 6);

        // Reset after 2 of 4 beats discards the partial sum.
        in_valid = 1'b1; cfg_len = 8'd4; cfg_frac = 3'd0;
        in_data = 16'd50; step();
        in_data = 16'd60; step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t6/rst_out_valid", longint'(out_valid), 0);
        check_eq("t6/rst_in_ready", longint'(in_ready), 1);
        check_eq("t6/rst_out_data", longint'($signed(out_data)), 0);
        for (int i = 0; i < 4; i++) beats[i] = 1;
        run_block("t6", 4, 0, 4, 4, 0, 0, 0, 4);

        // Longest block at full-scale input, which exercises accumulator headroom.
        for (int i = 0; i < 255; i++) beats[i] = 32767;
        run_block("long_pos", 255, 3, 255, 255, 3, 0, 0, model_result(255, 3));
        for (int i = 0; i < 255; i++) beats[i] = -32768;
        run_block("long_neg", 255, 0, 255, 255, 0, 0, 0, model_result(255, 0));

        // Random blocks.
        for (int b = 0; b < 60; b++) begin
            len_cfg = int'($urandom_range(0, 20));
            n       = (len_cfg == 0) ? 1 : len_cfg;
            frac    = int'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    beats[i] = int'($urandom_range(0, 4000)) - 2000;
                end else begin
                    r16 = 16'($urandom);
                    beats[i] = int'($signed(r16));
                end
            end
            run_block("rand", len_cfg, frac, n, int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      2, model_result(n, frac));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
